id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline.
- Captures decoded operands, register indices and control bits from ID.
- Presents IDEXRs/IDEXRt/IDEXRegWrite etc. to EX; these are the indices the forwarding unit compares against EX/MEM and MEM/WB destinations.
- Generates the PC/IF-ID write-enables that freeze the front end during a load-use bubble, and counts stall cycles for performance analysis.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_W, 5, register index width
- CNT_W, 16, stall counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- IFIDRs_i  in  REG_W  Rs index of instruction in ID
- IFIDRt_i  in  REG_W  Rt index of instruction in ID
- IFIDRd_i  in  REG_W  Rd index of instruction in ID
- RsData_i  in  DATA_W  register-file read data for Rs
- RtData_i  in  DATA_W  register-file read data for Rt
- Imm_i  in  DATA_W  sign-extended immediate
- RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, ALUSrc_i, RegDst_i  in  1 each  decoded control
- ALUOp_i  in  2  decoded ALU op class
- Flush_i  in  1  squash instruction in ID (taken branch/jump)
- ExtStall_i  in  1  hold whole pipeline (e.g. memory wait)
- IDEXRs_o, IDEXRt_o, IDEXRd_o  out  REG_W  registered indices
- IDEXRsData_o, IDEXRtData_o, IDEXImm_o  out  DATA_W  registered data
- IDEXRegWrite_o, IDEXMemRead_o, IDEXMemWrite_o, IDEXMemtoReg_o, IDEXALUSrc_o, IDEXRegDst_o  out  1 each  registered control
- IDEXALUOp_o  out  2  registered ALU op
- IDEXValid_o  out  1  1 = real instruction, 0 = bubble
- HazardStall_o  out  1  load-use stall asserted this cycle (combinational)
- PCWrite_o  out  1  PC update enable (combinational)
- IFIDWrite_o  out  1  IF/ID register enable (combinational)
- StallCount_o  out  CNT_W  load-use stall cycles since reset

Behaviour:
- Reset (rst_n_i=0, asynchronous): all registered outputs 0; IDEXValid_o=0; StallCount_o=0. Combinational outputs follow their equations from the reset state.
- Load-use condition LU = IDEXValid_o & IDEXMemRead_o & (IDEXRt_o != 0) & (IDEXRt_o == IFIDRs_i | IDEXRt_o == IFIDRt_i).
- HazardStall_o = LU & ~Flush_i.
- PCWrite_o = IFIDWrite_o = ~(HazardStall_o | ExtStall_i).
- Register update priority per rising edge:
  - 1. Flush_i=1: load bubble.
  - 2. ExtStall_i=1: hold all registers unchanged.
  - 3. HazardStall_o=1: load bubble.
  - 4. Otherwise: load all inputs, IDEXValid_o=1.
- Bubble: all control outputs, IDEXALUOp_o, IDEXValid_o, all index and data fields set to 0. Zero indices guarantee no forwarding match and no spurious LU.
- Latency: exactly one cycle from ID inputs to outputs when not stalled.
- Load-use produces exactly one bubble per dependent instruction.
  - Cycle after the bubble: IDEXMemRead_o=0, so LU drops and the held ID instruction loads normally.
- Flush during ExtStall: Flush wins and the bubble is loaded. The Flush source must deassert after one accepted cycle.
- StallCount_o: +1 on each edge where HazardStall_o=1 and ExtStall_i=0. Saturates at all-ones (no wrap). Cleared only by reset.
- Reset asserted mid-stall: outputs clear immediately. After release, the first edge loads ID normally, because IDEXValid_o=0 and so LU=0.

Test Plan:
1. Reset: drive inputs non-zero, pulse rst_n_i low between edges -> all registered outputs 0 immediately; PCWrite_o=1, IFIDWrite_o=1.
2. Normal flow: IFIDRs=3, Rt=4, Rd=5, RegWrite=1, RsData=0x11 -> next edge IDEXRs_o=3, IDEXRt_o=4, IDEXRd_o=5, IDEXRsData_o=0x11, IDEXValid_o=1.
3. Load-use: lw to $8 in EX, add $9,$8,$2 in ID -> HazardStall_o=1, PCWrite_o=0; next edge bubble (Valid=0, RegWrite=0); following edge the add loads; StallCount_o=1.
4. $0 exemption: lw to $0 followed by a use of $0 -> HazardStall_o=0, no bubble, StallCount_o unchanged.
5. ExtStall then Flush: ExtStall_i=1 for 3 cycles -> outputs held and PCWrite_o=0; then Flush_i=1 with ExtStall_i=1 -> bubble loaded, IDEXValid_o=0.
6. Saturation: CNT_W=2, force 5 load-use stalls -> StallCount_o sequence 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating stall counter.
// One-cycle latency; a load-use bubble or an external stall freezes PC and IF/ID via combinational enables.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [REG_W-1:0]  IFIDRs_i,
  input  logic [REG_W-1:0]  IFIDRt_i,
  input  logic [REG_W-1:0]  IFIDRd_i,
  input  logic [DATA_W-1:0] RsData_i,
  input  logic [DATA_W-1:0] RtData_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              MemtoReg_i,
  input  logic              ALUSrc_i,
  input  logic              RegDst_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              Flush_i,
  input  logic              ExtStall_i,
  output logic [REG_W-1:0]  IDEXRs_o,
  output logic [REG_W-1:0]  IDEXRt_o,
  output logic [REG_W-1:0]  IDEXRd_o,
  output logic [DATA_W-1:0] IDEXRsData_o,
  output logic [DATA_W-1:0] IDEXRtData_o,
  output logic [DATA_W-1:0] IDEXImm_o,
  output logic              IDEXRegWrite_o,
  output logic              IDEXMemRead_o,
  output logic              IDEXMemWrite_o,
  output logic              IDEXMemtoReg_o,
  output logic              IDEXALUSrc_o,
  output logic              IDEXRegDst_o,
  output logic [1:0]        IDEXALUOp_o,
  output logic              IDEXValid_o,
  output logic              HazardStall_o,
  output logic              PCWrite_o,
  output logic              IFIDWrite_o,
  output logic [CNT_W-1:0]  StallCount_o
);

  typedef struct packed {
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic              reg_dst;
    logic [1:0]        alu_op;
    logic              valid;
  } idex_t;

  idex_t            idex_q;
  idex_t            idex_d;
  logic             load_use;
  logic             bubble;
  logic             load;
  logic [CNT_W-1:0] stall_cnt_q;

  // $0 is never a real dependency, so a load targeting it cannot stall.
  assign load_use = idex_q.valid & idex_q.mem_read & (idex_q.rt != '0) &
                    ((idex_q.rt == IFIDRs_i) | (idex_q.rt == IFIDRt_i));

  assign HazardStall_o = load_use & ~Flush_i;
  assign PCWrite_o     = ~(HazardStall_o | ExtStall_i);
  assign IFIDWrite_o   = PCWrite_o;

  // Flush beats an external stall; a hazard bubble only goes in when the pipe moves.
  assign bubble = Flush_i | (~ExtStall_i & HazardStall_o);
  assign load   = ~Flush_i & ~ExtStall_i & ~HazardStall_o;

  always_comb begin
    idex_d            = '0;
    idex_d.rs         = IFIDRs_i;
    idex_d.rt         = IFIDRt_i;
    idex_d.rd         = IFIDRd_i;
    idex_d.rs_data    = RsData_i;
    idex_d.rt_data    = RtData_i;
    idex_d.imm        = Imm_i;
    idex_d.reg_write  = RegWrite_i;
    idex_d.mem_read   = MemRead_i;
    idex_d.mem_write  = MemWrite_i;
    idex_d.mem_to_reg = MemtoReg_i;
    idex_d.alu_src    = ALUSrc_i;
    idex_d.reg_dst    = RegDst_i;
    idex_d.alu_op     = ALUOp_i;
    idex_d.valid      = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idex_q <= '0;
    end else if (bubble) begin
      idex_q <= '0;
    end else if (load) begin
      idex_q <= idex_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else if (HazardStall_o && !ExtStall_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign IDEXRs_o       = idex_q.rs;
  assign IDEXRt_o       = idex_q.rt;
  assign IDEXRd_o       = idex_q.rd;
  assign IDEXRsData_o   = idex_q.rs_data;
  assign IDEXRtData_o   = idex_q.rt_data;
  assign IDEXImm_o      = idex_q.imm;
  assign IDEXRegWrite_o = idex_q.reg_write;
  assign IDEXMemRead_o  = idex_q.mem_read;
  assign IDEXMemWrite_o = idex_q.mem_write;
  assign IDEXMemtoReg_o = idex_q.mem_to_reg;
  assign IDEXALUSrc_o   = idex_q.alu_src;
  assign IDEXRegDst_o   = idex_q.reg_dst;
  assign IDEXALUOp_o    = idex_q.alu_op;
  assign IDEXValid_o    = idex_q.valid;
  assign StallCount_o   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: a default instance plus a CNT_W=2 instance sharing the same stimulus.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  if_rs = '0, if_rt = '0, if_rd = '0;
  logic [31:0] rs_data = '0, rt_data = '0, imm = '0;
  logic [7:0]  ctl = '0;
  logic        flush = 1'b0, ext = 1'b0;

  logic [4:0]  o_rs, o_rt, o_rd;
  logic [31:0] o_rsd, o_rtd, o_imm;
  logic        o_rw, o_mr, o_mw, o_m2r, o_as, o_rdst, o_vld, o_haz, o_pcw, o_ifw;
  logic [1:0]  o_aluop;
  logic [15:0] o_cnt;

  logic [4:0]  s_rs, s_rt, s_rd;
  logic [31:0] s_rsd, s_rtd, s_imm;
  logic        s_rw, s_mr, s_mw, s_m2r, s_as, s_rdst, s_vld, s_haz, s_pcw, s_ifw;
  logic [1:0]  s_aluop;
  logic [1:0]  s_cnt;

  logic [7:0]  o_ctl;
  assign o_ctl = {o_rw, o_mr, o_mw, o_m2r, o_as, o_rdst, o_aluop};

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .IFIDRs_i(if_rs), .IFIDRt_i(if_rt), .IFIDRd_i(if_rd),
    .RsData_i(rs_data), .RtData_i(rt_data), .Imm_i(imm),
    .RegWrite_i(ctl[7]), .MemRead_i(ctl[6]), .MemWrite_i(ctl[5]), .MemtoReg_i(ctl[4]),
    .ALUSrc_i(ctl[3]), .RegDst_i(ctl[2]), .ALUOp_i(ctl[1:0]),
    .Flush_i(flush), .ExtStall_i(ext),
    .IDEXRs_o(o_rs), .IDEXRt_o(o_rt), .IDEXRd_o(o_rd),
    .IDEXRsData_o(o_rsd), .IDEXRtData_o(o_rtd), .IDEXImm_o(o_imm),
    .IDEXRegWrite_o(o_rw), .IDEXMemRead_o(o_mr), .IDEXMemWrite_o(o_mw), .IDEXMemtoReg_o(o_m2r),
    .IDEXALUSrc_o(o_as), .IDEXRegDst_o(o_rdst), .IDEXALUOp_o(o_aluop), .IDEXValid_o(o_vld),
    .HazardStall_o(o_haz), .PCWrite_o(o_pcw), .IFIDWrite_o(o_ifw), .StallCount_o(o_cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_n_i(rst_n),
    .IFIDRs_i(if_rs), .IFIDRt_i(if_rt), .IFIDRd_i(if_rd),
    .RsData_i(rs_data), .RtData_i(rt_data), .Imm_i(imm),
    .RegWrite_i(ctl[7]), .MemRead_i(ctl[6]), .MemWrite_i(ctl[5]), .MemtoReg_i(ctl[4]),
    .ALUSrc_i(ctl[3]), .RegDst_i(ctl[2]), .ALUOp_i(ctl[1:0]),
    .Flush_i(flush), .ExtStall_i(ext),
    .IDEXRs_o(s_rs), .IDEXRt_o(s_rt), .IDEXRd_o(s_rd),
    .IDEXRsData_o(s_rsd), .IDEXRtData_o(s_rtd), .IDEXImm_o(s_imm),
    .IDEXRegWrite_o(s_rw), .IDEXMemRead_o(s_mr), .IDEXMemWrite_o(s_mw), .IDEXMemtoReg_o(s_m2r),
    .IDEXALUSrc_o(s_as), .IDEXRegDst_o(s_rdst), .IDEXALUOp_o(s_aluop), .IDEXValid_o(s_vld),
    .HazardStall_o(s_haz), .PCWrite_o(s_pcw), .IFIDWrite_o(s_ifw), .StallCount_o(s_cnt)
  );

  // ctl = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp[1:0]}
  typedef struct {
    string       name;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic [7:0]  ctl;
    logic        flush, ext;
    logic        e_haz, e_pcw, e_vld;
    logic [4:0]  e_rs, e_rt, e_rd;
    logic [31:0] e_rsd, e_rtd, e_imm;
    logic [7:0]  e_ctl;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic apply(input vec_t v);
    logic [1:0] sat_exp;
    if_rs = v.rs; if_rt = v.rt; if_rd = v.rd;
    rs_data = v.rsd; rt_data = v.rtd; imm = v.imm;
    ctl = v.ctl; flush = v.flush; ext = v.ext;
    #2;
    chk({v.name, ".haz"},  {31'd0, o_haz}, {31'd0, v.e_haz});
    chk({v.name, ".pcw"},  {31'd0, o_pcw}, {31'd0, v.e_pcw});
    chk({v.name, ".ifw"},  {31'd0, o_ifw}, {31'd0, v.e_pcw});
    @(posedge clk); #1;
    chk({v.name, ".vld"},  {31'd0, o_vld}, {31'd0, v.e_vld});
    chk({v.name, ".rs"},   {27'd0, o_rs},  {27'd0, v.e_rs});
    chk({v.name, ".rt"},   {27'd0, o_rt},  {27'd0, v.e_rt});
    chk({v.name, ".rd"},   {27'd0, o_rd},  {27'd0, v.e_rd});
    chk({v.name, ".rsd"},  o_rsd, v.e_rsd);
    chk({v.name, ".rtd"},  o_rtd, v.e_rtd);
    chk({v.name, ".imm"},  o_imm, v.e_imm);
    chk({v.name, ".ctl"},  {24'd0, o_ctl}, {24'd0, v.e_ctl});
    chk({v.name, ".cnt"},  {16'd0, o_cnt}, {16'd0, v.e_cnt});
    sat_exp = (v.e_cnt > 16'd3) ? 2'd3 : v.e_cnt[1:0];
    chk({v.name, ".satcnt"}, {30'd0, s_cnt}, {30'd0, sat_exp});
    @(negedge clk);
  endtask

  int sat_seq[5] = '{1, 2, 3, 3, 3};

  initial begin
    //             name           rs  rt  rd  rsd     rtd    imm    ctl    fl ex  haz pcw vld  ers ert erd ersd    ertd   eimm   ectl   cnt
    vecs[0]  = '{"normal",        3,  4,  5,  'h11,   'h22,  0,     'h80,  0, 0,  0,  1,  1,   3,  4,  5,  'h11,   'h22,  0,     'h80,  0};
    vecs[1]  = '{"lw8",           1,  8,  0,  'h100,  0,     4,     'hD8,  0, 0,  0,  1,  1,   1,  8,  0,  'h100,  0,     4,     'hD8,  0};
    vecs[2]  = '{"lu_rs",         8,  2,  9,  'hAA,   'hBB,  0,     'h86,  0, 0,  1,  0,  0,   0,  0,  0,  0,      0,     0,     0,     1};
    vecs[3]  = '{"lu_reload",     8,  2,  9,  'hAA,   'hBB,  0,     'h86,  0, 0,  0,  1,  1,   8,  2,  9,  'hAA,   'hBB,  0,     'h86,  1};
    vecs[4]  = '{"lw7",           1,  7,  0,  'h200,  0,     8,     'hD8,  0, 0,  0,  1,  1,   1,  7,  0,  'h200,  0,     8,     'hD8,  1};
    vecs[5]  = '{"lu_rt",         3,  7,  10, 'h33,   'h44,  0,     'h86,  0, 0,  1,  0,  0,   0,  0,  0,  0,      0,     0,     0,     2};
    vecs[6]  = '{"lu_rt_reload",  3,  7,  10, 'h33,   'h44,  0,     'h86,  0, 0,  0,  1,  1,   3,  7,  10, 'h33,   'h44,  0,     'h86,  2};
    vecs[7]  = '{"lw0",           1,  0,  0,  'h300,  0,     'hC,   'hD8,  0, 0,  0,  1,  1,   1,  0,  0,  'h300,  0,     'hC,   'hD8,  2};
    vecs[8]  = '{"use0",          0,  0,  11, 0,      0,     0,     'h86,  0, 0,  0,  1,  1,   0,  0,  11, 0,      0,     0,     'h86,  2};
    vecs[9]  = '{"lw5",           2,  5,  0,  'h400,  0,     'h10,  'hD8,  0, 0,  0,  1,  1,   2,  5,  0,  'h400,  0,     'h10,  'hD8,  2};
    vecs[10] = '{"lu_flush",      5,  6,  12, 'h55,   'h56,  0,     'h86,  1, 0,  0,  1,  0,   0,  0,  0,  0,      0,     0,     0,     2};
    vecs[11] = '{"pre_ext",       13, 14, 15, 'h66,   'h67,  0,     'h86,  0, 0,  0,  1,  1,   13, 14, 15, 'h66,   'h67,  0,     'h86,  2};
    vecs[12] = '{"ext_hold1",     1,  2,  3,  'h77,   'h78,  'h14,  'h28,  0, 1,  0,  0,  1,   13, 14, 15, 'h66,   'h67,  0,     'h86,  2};
    vecs[13] = '{"ext_hold2",     1,  2,  3,  'h77,   'h78,  'h14,  'h28,  0, 1,  0,  0,  1,   13, 14, 15, 'h66,   'h67,  0,     'h86,  2};
    vecs[14] = '{"ext_hold3",     1,  2,  3,  'h77,   'h78,  'h14,  'h28,  0, 1,  0,  0,  1,   13, 14, 15, 'h66,   'h67,  0,     'h86,  2};
    vecs[15] = '{"ext_flush",     1,  2,  3,  'h77,   'h78,  'h14,  'h28,  1, 1,  0,  0,  0,   0,  0,  0,  0,      0,     0,     0,     2};
    vecs[16] = '{"lw9",           1,  9,  0,  'h500,  0,     'h18,  'hD8,  0, 0,  0,  1,  1,   1,  9,  0,  'h500,  0,     'h18,  'hD8,  2};
    vecs[17] = '{"lu_ext",        9,  1,  4,  'h99,   'h9A,  0,     'h86,  0, 1,  1,  0,  1,   1,  9,  0,  'h500,  0,     'h18,  'hD8,  2};
    vecs[18] = '{"lu_noext",      9,  1,  4,  'h99,   'h9A,  0,     'h86,  0, 0,  1,  0,  0,   0,  0,  0,  0,      0,     0,     0,     3};
    vecs[19] = '{"lu_reload2",    9,  1,  4,  'h99,   'h9A,  0,     'h86,  0, 0,  0,  1,  1,   9,  1,  4,  'h99,   'h9A,  0,     'h86,  3};

    // Reset state, with the combinational enables derived from it.
    #2;
    chk("rst.vld", {31'd0, o_vld}, 32'd0);
    chk("rst.cnt", {16'd0, o_cnt}, 32'd0);
    chk("rst.ctl", {24'd0, o_ctl}, 32'd0);
    chk("rst.pcw", {31'd0, o_pcw}, 32'd1);
    chk("rst.ifw", {31'd0, o_ifw}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) apply(vecs[i]);

    // Reset pulsed between edges while a load-use stall is active.
    if_rs = 1; if_rt = 8; if_rd = 0; rs_data = 'h600; rt_data = 0; imm = 4; ctl = 'hD8;
    flush = 0; ext = 0;
    @(posedge clk); #1;
    @(negedge clk);
    if_rs = 8; if_rt = 3; if_rd = 9; rs_data = 'hAA; rt_data = 'hBB; imm = 5; ctl = 'h86;
    #1;
    chk("midrst.haz_before", {31'd0, o_haz}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.vld",    {31'd0, o_vld}, 32'd0);
    chk("midrst.rs",     {27'd0, o_rs},  32'd0);
    chk("midrst.rt",     {27'd0, o_rt},  32'd0);
    chk("midrst.rsd",    o_rsd, 32'd0);
    chk("midrst.ctl",    {24'd0, o_ctl}, 32'd0);
    chk("midrst.cnt",    {16'd0, o_cnt}, 32'd0);
    chk("midrst.satcnt", {30'd0, s_cnt}, 32'd0);
    chk("midrst.haz",    {31'd0, o_haz}, 32'd0);
    chk("midrst.pcw",    {31'd0, o_pcw}, 32'd1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst.vld", {31'd0, o_vld}, 32'd1);
    chk("postrst.rs",  {27'd0, o_rs},  32'd8);
    chk("postrst.rt",  {27'd0, o_rt},  32'd3);
    chk("postrst.imm", o_imm, 32'd5);
    chk("postrst.ctl", {24'd0, o_ctl}, 32'h86);
    chk("postrst.cnt", {16'd0, o_cnt}, 32'd0);

    // lw $8,0($8) held in ID: alternates load / bubble, one stall per pair of edges.
    @(negedge clk);
    if_rs = 8; if_rt = 8; if_rd = 0; rs_data = 1; rt_data = 0; imm = 0; ctl = 'hD8;
    @(posedge clk); #1;
    chk("sat.first_load", {31'd0, o_vld}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk($sformatf("sat%0d.haz", k), {31'd0, o_haz}, 32'd1);
      @(posedge clk); #1;
      chk($sformatf("sat%0d.bubble", k), {31'd0, o_vld}, 32'd0);
      chk($sformatf("sat%0d.cnt", k), {16'd0, o_cnt}, k + 1);
      chk($sformatf("sat%0d.satcnt", k), {30'd0, s_cnt}, sat_seq[k]);
      @(posedge clk); #1;
      chk($sformatf("sat%0d.reload", k), {31'd0, o_vld}, 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
